// File: rtl/regs_wb_ctrl.sv
// regs_wb_ctrl
// Write-back driver for the 32x32 integer register file. It merges
// single-cycle EX results and out-of-order LSU load returns onto the single
// registered write port. EX always has priority. Load returns that cannot be
// written straight away wait in a small FIFO, which keeps their order.
//
// Optional feature: define WB_SCOREBOARD_EN to add a busy bitmap of
// outstanding load destinations. ID then sees hazard_o when one of its
// operands is still waiting for its load. When the macro is undefined,
// hazard_o is tied to 0 and the issue_* inputs are ignored.
//
// Ports
//   clk, rst_n                       clock, async active-low reset
//   ex_wen_i/ex_waddr_i/ex_wdata_i   EX result (cannot be stalled)
//   lsu_valid_i/lsu_ready_o          load return handshake
//   lsu_waddr_i/lsu_wdata_i          load return destination and data
//   issue_valid_i/issue_waddr_i      load issue (marks the destination busy)
//   id_reg1_raddr_i/id_reg2_raddr_i  ID operand indices
//   hazard_o                         an ID operand is busy
//   reg_wen_o/reg_waddr_o/reg_wdata_o registered register file write port
module regs_wb_ctrl #(
    parameter int FIFO_DEPTH = 2,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_wen_i,
    input  logic [ADDR_W-1:0] ex_waddr_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic              lsu_valid_i,
    output logic              lsu_ready_o,
    input  logic [ADDR_W-1:0] lsu_waddr_i,
    input  logic [DATA_W-1:0] lsu_wdata_i,
    input  logic              issue_valid_i,
    input  logic [ADDR_W-1:0] issue_waddr_i,
    input  logic [ADDR_W-1:0] id_reg1_raddr_i,
    input  logic [ADDR_W-1:0] id_reg2_raddr_i,
    output logic              hazard_o,
    output logic              reg_wen_o,
    output logic [ADDR_W-1:0] reg_waddr_o,
    output logic [DATA_W-1:0] reg_wdata_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    logic              full;
    logic              empty;
    logic              ex_used;
    logic              lsu_acc;
    logic              lsu_live;
    logic              pop;
    logic              bypass;
    logic              push;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              lsu_wr;
    logic [ADDR_W-1:0] lsu_wr_addr;

    assign full        = (count == CNT_W'(FIFO_DEPTH));
    assign empty       = (count == '0);
    // Readiness comes only from the registered count. A pop in the same
    // cycle does not free a slot for a push.
    assign lsu_ready_o = !full;

    assign ex_used  = ex_wen_i && (ex_waddr_i != '0);
    assign lsu_acc  = lsu_valid_i && !full;
    // A load return to x0 is accepted and then dropped.
    assign lsu_live = lsu_acc && (lsu_waddr_i != '0);
    assign pop      = !ex_used && !empty;
    assign bypass   = !ex_used && empty && lsu_live;
    assign push     = lsu_live && !bypass;

    always_comb begin
        wr_en       = 1'b0;
        wr_addr     = reg_waddr_o;
        wr_data     = reg_wdata_o;
        lsu_wr      = 1'b0;
        lsu_wr_addr = lsu_waddr_i;
        if (ex_used) begin
            wr_en   = 1'b1;
            wr_addr = ex_waddr_i;
            wr_data = ex_wdata_i;
        end else if (pop) begin
            wr_en       = 1'b1;
            wr_addr     = fifo_addr[rd_ptr];
            wr_data     = fifo_data[rd_ptr];
            lsu_wr      = 1'b1;
            lsu_wr_addr = fifo_addr[rd_ptr];
        end else if (bypass) begin
            wr_en   = 1'b1;
            wr_addr = lsu_waddr_i;
            wr_data = lsu_wdata_i;
            lsu_wr  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_wen_o   <= 1'b0;
            reg_waddr_o <= '0;
            reg_wdata_o <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            reg_wen_o   <= wr_en;
            reg_waddr_o <= wr_addr;
            reg_wdata_o <= wr_data;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // The storage holds only data, so it is not reset. The count alone says
    // which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= lsu_waddr_i;
            fifo_data[wr_ptr] <= lsu_wdata_i;
        end
    end

`ifdef WB_SCOREBOARD_EN
    localparam int NREG = 2 ** ADDR_W;

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_set;
    logic [NREG-1:0] busy_clr;

    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (issue_valid_i && (issue_waddr_i != '0)) busy_set[issue_waddr_i] = 1'b1;
        if (lsu_wr) busy_clr[lsu_wr_addr] = 1'b1;
    end

    // The set is applied after the clear. A re-issue in the same cycle as
    // the write therefore keeps the register busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= (busy & ~busy_clr) | busy_set;
    end

    assign hazard_o = busy[id_reg1_raddr_i] | busy[id_reg2_raddr_i];
`else
    logic unused_sb;
    assign unused_sb = ^{issue_valid_i, issue_waddr_i, id_reg1_raddr_i,
                         id_reg2_raddr_i, lsu_wr, lsu_wr_addr};
    assign hazard_o  = 1'b0;
`endif

endmodule

// File: tb/tb_regs_wb_ctrl.sv
module tb_regs_wb_ctrl;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_wen = 1'b0;
    logic [4:0]  ex_waddr = '0;
    logic [31:0] ex_wdata = '0;
    logic        lsu_valid = 1'b0;
    logic        lsu_ready;
    logic [4:0]  lsu_waddr = '0;
    logic [31:0] lsu_wdata = '0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_waddr = '0;
    logic [4:0]  id_r1 = '0;
    logic [4:0]  id_r2 = '0;
    logic        hazard;
    logic        reg_wen;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef WB_SCOREBOARD_EN
    localparam bit SB_ON = 1'b1;
`else
    localparam bit SB_ON = 1'b0;
`endif

    // Reference model: pending loads as a queue of {addr, data}, and a busy
    // bit per register.
    logic [36:0] mq[$];
    bit [31:0]   sb;
    logic        e_wen;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;

    regs_wb_ctrl #(.FIFO_DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_wen_i(ex_wen), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata),
        .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready),
        .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata),
        .issue_valid_i(issue_valid), .issue_waddr_i(issue_waddr),
        .id_reg1_raddr_i(id_r1), .id_reg2_raddr_i(id_r2),
        .hazard_o(hazard),
        .reg_wen_o(reg_wen), .reg_waddr_o(reg_waddr), .reg_wdata_o(reg_wdata)
    );

    always #5 clk = ~clk;

    task automatic idle();
        ex_wen = 0; ex_waddr = 0; ex_wdata = 0;
        lsu_valid = 0; lsu_waddr = 0; lsu_wdata = 0;
        issue_valid = 0; issue_waddr = 0; id_r1 = 0; id_r2 = 0;
    endtask

    task automatic model_reset();
        mq.delete();
        sb = '0;
        e_wen = 0; e_waddr = 0; e_wdata = 0;
    endtask

    function automatic bit exp_ready();
        return mq.size() < DEPTH;
    endfunction

    function automatic bit exp_hazard();
        return SB_ON & (sb[id_r1] | sb[id_r2]);
    endfunction

    // Applies one clock edge to the model and then to the DUT. On return,
    // the time is just after the edge.
    task automatic tick();
        logic [36:0] h;
        bit acc;
        bit took;
        acc  = lsu_valid && (mq.size() < DEPTH);
        took = 0;
        if (ex_wen && ex_waddr != 0) begin
            e_wen = 1; e_waddr = ex_waddr; e_wdata = ex_wdata;
        end else if (mq.size() > 0) begin
            h = mq.pop_front();
            e_wen = 1; e_waddr = h[36:32]; e_wdata = h[31:0];
            sb[h[36:32]] = 0;
        end else if (acc && lsu_waddr != 0) begin
            e_wen = 1; e_waddr = lsu_waddr; e_wdata = lsu_wdata;
            sb[lsu_waddr] = 0;
            took = 1;
        end else begin
            e_wen = 0;
        end
        if (acc && lsu_waddr != 0 && !took) mq.push_back({lsu_waddr, lsu_wdata});
        if (issue_valid && issue_waddr != 0) sb[issue_waddr] = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        model_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({reg_wen, reg_waddr, reg_wdata} !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got wen=%b addr=%0d data=%h required all zero", reg_wen, reg_waddr, reg_wdata);
        end
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (reg_wen !== 1'b0 || lsu_ready !== 1'b1 || hazard !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle cyc%0d: got wen=%b ready=%b hazard=%b required 0/1/0", i, reg_wen, lsu_ready, hazard);
            end
            tick();
        end
    endtask

    task automatic test_ex();
        idle();
        ex_wen = 1; ex_waddr = 5; ex_wdata = 32'h1234;
        tick();
        n_checks++;
        if (reg_wen !== 1'b1 || reg_waddr !== 5'd5 || reg_wdata !== 32'h1234) begin
            n_fail++;
            $display("FAIL ex_x5: got wen=%b addr=%0d data=%h required 1/5/00001234", reg_wen, reg_waddr, reg_wdata);
        end
        ex_waddr = 0; ex_wdata = 32'h9999;
        tick();
        n_checks++;
        if (reg_wen !== 1'b0 || reg_waddr !== 5'd5 || reg_wdata !== 32'h1234) begin
            n_fail++;
            $display("FAIL ex_x0: got wen=%b addr=%0d data=%h required 0/5/00001234", reg_wen, reg_waddr, reg_wdata);
        end
        idle();
        tick();
    endtask

    task automatic test_bypass();
        idle();
        lsu_valid = 1; lsu_waddr = 7; lsu_wdata = 32'hDEAD;
        tick();
        idle();
        n_checks++;
        if (reg_wen !== 1'b1 || reg_waddr !== 5'd7 || reg_wdata !== 32'hDEAD) begin
            n_fail++;
            $display("FAIL bypass_x7: got wen=%b addr=%0d data=%h required 1/7/0000dead", reg_wen, reg_waddr, reg_wdata);
        end
        tick();
        n_checks++;
        if (reg_wen !== 1'b0 || lsu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bypass_fifo_empty: got wen=%b ready=%b required 0/1", reg_wen, lsu_ready);
        end
    endtask

    task automatic test_ex_priority();
        logic [4:0]  wa[5];
        logic [31:0] wd[5];
        logic        rdy[6];
        idle();
        for (int c = 0; c < 5; c++) begin
            idle();
            if (c < 3) begin ex_wen = 1; ex_waddr = 1; ex_wdata = 32'h100 + c; end
            if (c == 0) begin lsu_valid = 1; lsu_waddr = 8; lsu_wdata = 32'hA; end
            if (c == 1) begin lsu_valid = 1; lsu_waddr = 9; lsu_wdata = 32'hB; end
            #1;
            rdy[c] = lsu_ready;
            tick();
            wa[c] = reg_waddr;
            wd[c] = reg_wdata;
            n_checks++;
            if (reg_wen !== 1'b1) begin
                n_fail++;
                $display("FAIL prio_wen cyc%0d: got %b required 1", c, reg_wen);
            end
        end
        idle();
        #1;
        rdy[5] = lsu_ready;
        n_checks++;
        if (wa[0] !== 1 || wa[1] !== 1 || wa[2] !== 1 || wa[3] !== 8 || wa[4] !== 9 ||
            wd[0] !== 32'h100 || wd[2] !== 32'h102 || wd[3] !== 32'hA || wd[4] !== 32'hB) begin
            n_fail++;
            $display("FAIL prio_order: got %0d,%0d,%0d,%0d=%h,%0d=%h required 1,1,1,8=a,9=b",
                     wa[0], wa[1], wa[2], wa[3], wd[3], wa[4], wd[4]);
        end
        n_checks++;
        if ({rdy[0], rdy[1], rdy[2], rdy[3], rdy[4], rdy[5]} !== 6'b110011) begin
            n_fail++;
            $display("FAIL prio_ready: got %b%b%b%b%b%b required 110011",
                     rdy[0], rdy[1], rdy[2], rdy[3], rdy[4], rdy[5]);
        end
        tick();
    endtask

    task automatic test_scoreboard();
        idle();
        issue_valid = 1; issue_waddr = 3; id_r1 = 3;
        #1;
        n_checks++;
        if (hazard !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_before_issue: got %b required 0", hazard);
        end
        tick();
        idle();
        id_r2 = 3;
        #1;
        n_checks++;
        if (hazard !== SB_ON) begin
            n_fail++;
            $display("FAIL sb_busy: got %b required %b", hazard, SB_ON);
        end
        lsu_valid = 1; lsu_waddr = 3; lsu_wdata = 32'h55;
        tick();
        lsu_valid = 0;
        #1;
        n_checks++;
        if (hazard !== 1'b0 || reg_wen !== 1'b1 || reg_waddr !== 5'd3) begin
            n_fail++;
            $display("FAIL sb_cleared: got hazard=%b wen=%b addr=%0d required 0/1/3", hazard, reg_wen, reg_waddr);
        end
        issue_valid = 1; issue_waddr = 3;
        tick();
        lsu_valid = 1; lsu_waddr = 3; lsu_wdata = 32'h66;
        tick();
        idle();
        id_r1 = 3;
        #1;
        n_checks++;
        if (hazard !== SB_ON || reg_wen !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_set_clear_same: got hazard=%b wen=%b required %b/1", hazard, reg_wen, SB_ON);
        end
        lsu_valid = 1; lsu_waddr = 3; lsu_wdata = 32'h77;
        tick();
        idle();
        id_r1 = 3;
        #1;
        n_checks++;
        if (hazard !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_final_clear: got %b required 0", hazard);
        end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            ex_wen      = ($urandom_range(0, 99) < 40);
            ex_waddr    = 5'($urandom_range(0, 31));
            ex_wdata    = $urandom;
            lsu_valid   = ($urandom_range(0, 99) < 50);
            lsu_waddr   = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            lsu_wdata   = $urandom;
            issue_valid = ($urandom_range(0, 99) < 30);
            issue_waddr = 5'($urandom_range(0, 31));
            id_r1       = 5'($urandom_range(0, 31));
            id_r2       = 5'($urandom_range(0, 31));
            #1;
            n_checks++;
            if (lsu_ready !== exp_ready() || hazard !== exp_hazard()) begin
                n_fail++;
                $display("FAIL rand_comb cyc%0d: got ready=%b hazard=%b required %b/%b",
                         c, lsu_ready, hazard, exp_ready(), exp_hazard());
            end
            tick();
            n_checks++;
            if (reg_wen !== e_wen || reg_waddr !== e_waddr || reg_wdata !== e_wdata) begin
                n_fail++;
                $display("FAIL rand_write cyc%0d: got wen=%b addr=%0d data=%h required %b/%0d/%h",
                         c, reg_wen, reg_waddr, reg_wdata, e_wen, e_waddr, e_wdata);
            end
        end
        idle();
        repeat (4) tick();
    endtask

    task automatic test_reset_mid();
        idle();
        ex_wen = 1; ex_waddr = 1; ex_wdata = 32'h11;
        lsu_valid = 1; lsu_waddr = 8; lsu_wdata = 32'hA;
        tick();
        lsu_waddr = 9; lsu_wdata = 32'hB;
        tick();
        lsu_valid = 0;
        #1;
        n_checks++;
        if (lsu_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_full: got ready=%b required 0", lsu_ready);
        end
        #1;
        rst_n = 0;
        #1;
        n_checks++;
        if ({reg_wen, reg_waddr, reg_wdata} !== 38'd0 || lsu_ready !== 1'b1 || hazard !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_immediate: got wen=%b addr=%0d data=%h ready=%b hazard=%b required 0/0/0/1/0",
                     reg_wen, reg_waddr, reg_wdata, lsu_ready, hazard);
        end
        idle();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (reg_wen !== 1'b0 || lsu_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL rstmid_stale cyc%0d: got wen=%b addr=%0d ready=%b required wen 0 ready 1",
                         i, reg_wen, reg_waddr, lsu_ready);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_ex();
        test_bypass();
        test_ex_priority();
        test_scoreboard();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
